// File: rtl/pmem_arbiter_if.sv
// Bundle of the icache, dcache and physical-memory request/response lines
// that meet at the pmem_arbiter. The arbiter uses the slave view.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_stb;
  logic                  i_cyc;
  logic                  i_write;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_wdata;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  i_retry;

  logic                  d_stb;
  logic                  d_cyc;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  d_retry;

  logic                  mem_stb;
  logic                  mem_cyc;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;
  logic                  mem_retry;

  modport slave (
    input  i_stb, i_cyc, i_write, i_addr, i_wdata,
    output i_rdata, i_resp, i_retry,
    input  d_stb, d_cyc, d_write, d_addr, d_wdata,
    output d_rdata, d_resp, d_retry,
    output mem_stb, mem_cyc, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp, mem_retry
  );

  modport master (
    output i_stb, i_cyc, i_write, i_addr, i_wdata,
    input  i_rdata, i_resp, i_retry,
    output d_stb, d_cyc, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp, d_retry,
    input  mem_stb, mem_cyc, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp, mem_retry
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares the physical-memory port between icache and dcache controllers.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise dcache wins ties.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  pmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;   // 0 = icache, 1 = dcache

  logic i_req, d_req, tie_to_d;

  logic                  mem_stb_c, mem_cyc_c, mem_write_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [LINE_WIDTH-1:0] mem_wdata_c;
  logic [LINE_WIDTH-1:0] i_rdata_c, d_rdata_c;
  logic                  i_resp_c, i_retry_c, d_resp_c, d_retry_c;

  assign i_req = bus.i_stb & bus.i_cyc;
  assign d_req = bus.d_stb & bus.d_cyc;

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_d = ~last_grant;
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Every output is gated by rst_n so a reset mid-transaction drops the bus
  // in the very cycle it is asserted and suppresses any stray resp.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    mem_stb_c      = 1'b0;
    mem_cyc_c      = 1'b0;
    mem_write_c    = 1'b0;
    mem_addr_c     = '0;
    mem_wdata_c    = '0;
    i_rdata_c      = '0;
    d_rdata_c      = '0;
    i_resp_c       = 1'b0;
    i_retry_c      = 1'b0;
    d_resp_c       = 1'b0;
    d_retry_c      = 1'b0;

    if (rst_n) begin
      case (state)
        IDLE: begin
          if (i_req && d_req) begin
            state_nxt = tie_to_d ? GRANT_D : GRANT_I;
            i_retry_c = tie_to_d;
            d_retry_c = ~tie_to_d;
          end else if (i_req) begin
            state_nxt = GRANT_I;
          end else if (d_req) begin
            state_nxt = GRANT_D;
          end
        end

        GRANT_I: begin
          mem_stb_c   = 1'b1;
          mem_cyc_c   = 1'b1;
          mem_write_c = bus.i_write;
          mem_addr_c  = bus.i_addr;
          mem_wdata_c = bus.i_wdata;
          i_rdata_c   = bus.mem_rdata;
          i_resp_c    = bus.mem_resp;
          i_retry_c   = bus.mem_retry & ~bus.mem_resp;
          d_retry_c   = d_req;
          if (bus.mem_resp) begin
            state_nxt      = IDLE;
            last_grant_nxt = 1'b0;
          end
        end

        GRANT_D: begin
          mem_stb_c   = 1'b1;
          mem_cyc_c   = 1'b1;
          mem_write_c = bus.d_write;
          mem_addr_c  = bus.d_addr;
          mem_wdata_c = bus.d_wdata;
          d_rdata_c   = bus.mem_rdata;
          d_resp_c    = bus.mem_resp;
          d_retry_c   = bus.mem_retry & ~bus.mem_resp;
          i_retry_c   = i_req;
          if (bus.mem_resp) begin
            state_nxt      = IDLE;
            last_grant_nxt = 1'b1;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.mem_stb   = mem_stb_c;
  assign bus.mem_cyc   = mem_cyc_c;
  assign bus.mem_write = mem_write_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.i_rdata   = i_rdata_c;
  assign bus.i_resp    = i_resp_c;
  assign bus.i_retry   = i_retry_c;
  assign bus.d_rdata   = d_rdata_c;
  assign bus.d_resp    = d_resp_c;
  assign bus.d_retry   = d_retry_c;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: an ownership model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns memory (0 none, 1 icache, 2 dcache) and who was served last.
  int   m_owner = 0;
  logic m_last  = 1'b1;
  logic m_valid = 1'b0;
  logic m_ir, m_dr;

  logic [LW-1:0] pat_a5, pat_w, pat_w2, pat_rd;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tie_winner(input logic last);
`ifdef ARB_ROUND_ROBIN_EN
    return last ? 1 : 2;
`else
    return 2;
`endif
  endfunction

  always @(posedge clk) begin
    m_ir = bus.i_stb & bus.i_cyc;
    m_dr = bus.d_stb & bus.d_cyc;
    if (!rst_n) begin
      m_owner = 0;
      m_last  = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_owner == 0) begin
        if (m_ir && m_dr) m_owner = tie_winner(m_last);
        else if (m_ir)    m_owner = 1;
        else if (m_dr)    m_owner = 2;
      end else if (bus.mem_resp) begin
        m_last  = (m_owner == 2);
        m_owner = 0;
      end
    end
  end

  logic [6:0]    e_ctrl;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wdata, e_irdata, e_drdata;
  logic          c_ir, c_dr;

  always @(negedge clk) begin
    if (m_valid) begin
      e_ctrl = '0; e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
      c_ir = bus.i_stb & bus.i_cyc;
      c_dr = bus.d_stb & bus.d_cyc;
      if (rst_n) begin
        if (m_owner == 0) begin
          if (c_ir && c_dr) begin
            e_ctrl[2] = (tie_winner(m_last) == 2);
            e_ctrl[0] = (tie_winner(m_last) == 1);
          end
        end else if (m_owner == 1) begin
          e_ctrl   = {1'b1, 1'b1, bus.i_write, bus.mem_resp,
                      bus.mem_retry & ~bus.mem_resp, 1'b0, c_dr};
          e_addr   = bus.i_addr;
          e_wdata  = bus.i_wdata;
          e_irdata = bus.mem_rdata;
        end else begin
          e_ctrl   = {1'b1, 1'b1, bus.d_write, 1'b0, c_ir, bus.mem_resp,
                      bus.mem_retry & ~bus.mem_resp};
          e_addr   = bus.d_addr;
          e_wdata  = bus.d_wdata;
          e_drdata = bus.mem_rdata;
        end
      end
      chk("model_ctrl", {bus.mem_stb, bus.mem_cyc, bus.mem_write, bus.i_resp,
                         bus.i_retry, bus.d_resp, bus.d_retry}, e_ctrl);
      chk("model_mem_addr", bus.mem_addr, e_addr);
      chk("model_mem_wdata", bus.mem_wdata, e_wdata);
      chk("model_i_rdata", bus.i_rdata, e_irdata);
      chk("model_d_rdata", bus.d_rdata, e_drdata);
    end
  end

  // Inputs change 2 time units after the rising edge; literal checks 2 later.
  task automatic cyc_start();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_i(input logic req, input logic [AW-1:0] addr);
    bus.i_stb = req; bus.i_cyc = req; bus.i_addr = addr;
  endtask

  task automatic set_d(input logic req, input logic wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wd);
    bus.d_stb = req; bus.d_cyc = req; bus.d_write = wr; bus.d_addr = addr; bus.d_wdata = wd;
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w  = {8{32'hDEAD_BEEF}};
    pat_w2 = {8{32'h1234_5678}};
    pat_rd = {8{32'h0F0F_3C3C}};
    bus.i_write = 1'b0; bus.i_wdata = '0;
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0);
    bus.mem_rdata = '0; bus.mem_resp = 1'b0; bus.mem_retry = 1'b0;

    // Reset with activity on the inputs: every output must be zero.
    cyc_start();
    set_i(1'b1, 32'h0000_1000);
    bus.mem_rdata = pat_a5; bus.mem_resp = 1'b1; bus.mem_retry = 1'b1;
    settle();
    chk("rst_mem_stb", bus.mem_stb, 1'b0);
    chk("rst_i_retry", bus.i_retry, 1'b0);
    chk("rst_i_resp", bus.i_resp, 1'b0);
    chk("rst_i_rdata", bus.i_rdata, '0);

    // Single icache read at 0x1000.
    cyc_start();
    rst_n = 1'b1; bus.mem_resp = 1'b0; bus.mem_retry = 1'b0;
    settle();
    chk("rd_idle_mem_stb", bus.mem_stb, 1'b0);
    chk("rd_idle_i_retry", bus.i_retry, 1'b0);
    cyc_start();
    bus.mem_resp = 1'b1;
    settle();
    chk("rd_mem_stb", bus.mem_stb, 1'b1);
    chk("rd_mem_addr", bus.mem_addr, 32'h0000_1000);
    chk("rd_i_resp", bus.i_resp, 1'b1);
    chk("rd_i_rdata", bus.i_rdata, pat_a5);
    cyc_start();
    set_i(1'b0, '0); bus.mem_resp = 1'b0;
    settle();
    chk("rd_after_mem_stb", bus.mem_stb, 1'b0);

    // Tie right after reset: icache read 0x3000 vs dcache write-back 0x2000.
    cyc_start();
    rst_n = 1'b0;
    cyc_start();
    rst_n = 1'b1;
    set_i(1'b1, 32'h0000_3000);
    set_d(1'b1, 1'b1, 32'h0000_2000, pat_w);
    settle();
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_t0_d_retry", bus.d_retry, 1'b1);
    chk("tie_t0_i_retry", bus.i_retry, 1'b0);
    cyc_start();
    settle();
    chk("tie_t1_mem_addr", bus.mem_addr, 32'h0000_3000);
    chk("tie_t1_mem_write", bus.mem_write, 1'b0);
    chk("tie_t1_d_retry", bus.d_retry, 1'b1);
    cyc_start();
    bus.mem_resp = 1'b1; bus.mem_rdata = pat_rd;
    settle();
    chk("tie_t2_i_resp", bus.i_resp, 1'b1);
    chk("tie_t2_i_rdata", bus.i_rdata, pat_rd);
    chk("tie_t2_d_retry", bus.d_retry, 1'b1);
    cyc_start();
    set_i(1'b0, '0); bus.mem_resp = 1'b0;
    settle();
    chk("tie_t3_bubble", bus.mem_stb, 1'b0);
    chk("tie_t3_d_retry", bus.d_retry, 1'b0);
    cyc_start();
    bus.mem_resp = 1'b1;
    settle();
    chk("tie_t4_mem_write", bus.mem_write, 1'b1);
    chk("tie_t4_mem_addr", bus.mem_addr, 32'h0000_2000);
    chk("tie_t4_mem_wdata", bus.mem_wdata, pat_w);
    chk("tie_t4_d_resp", bus.d_resp, 1'b1);
    cyc_start();
    set_d(1'b0, 1'b0, '0, '0); bus.mem_resp = 1'b0;
`else
    chk("tie_t0_i_retry", bus.i_retry, 1'b1);
    chk("tie_t0_d_retry", bus.d_retry, 1'b0);
    cyc_start();
    settle();
    chk("tie_t1_mem_write", bus.mem_write, 1'b1);
    chk("tie_t1_mem_addr", bus.mem_addr, 32'h0000_2000);
    chk("tie_t1_i_retry", bus.i_retry, 1'b1);
    cyc_start();
    bus.mem_resp = 1'b1;
    settle();
    chk("tie_t2_d_resp", bus.d_resp, 1'b1);
    chk("tie_t2_i_retry", bus.i_retry, 1'b1);
    cyc_start();
    set_d(1'b0, 1'b0, '0, '0); bus.mem_resp = 1'b0;
    settle();
    chk("tie_t3_bubble", bus.mem_stb, 1'b0);
    chk("tie_t3_i_retry", bus.i_retry, 1'b0);
    cyc_start();
    bus.mem_resp = 1'b1; bus.mem_rdata = pat_rd;
    settle();
    chk("tie_t4_mem_addr", bus.mem_addr, 32'h0000_3000);
    chk("tie_t4_mem_write", bus.mem_write, 1'b0);
    chk("tie_t4_i_resp", bus.i_resp, 1'b1);
    chk("tie_t4_i_rdata", bus.i_rdata, pat_rd);
    cyc_start();
    set_i(1'b0, '0); bus.mem_resp = 1'b0;
`endif

    // mem_retry for three cycles during a dcache write-back.
    cyc_start();
    set_d(1'b1, 1'b1, 32'h0000_4000, pat_w2);
    cyc_start();
    for (int k = 0; k < 3; k++) begin
      bus.mem_retry = 1'b1;
      settle();
      chk("retry_d_retry", bus.d_retry, 1'b1);
      chk("retry_mem_stb", bus.mem_stb, 1'b1);
      chk("retry_mem_addr", bus.mem_addr, 32'h0000_4000);
      chk("retry_mem_wdata", bus.mem_wdata, pat_w2);
      chk("retry_d_resp", bus.d_resp, 1'b0);
      cyc_start();
    end
    bus.mem_resp = 1'b1;
    settle();
    chk("retry_end_d_resp", bus.d_resp, 1'b1);
    chk("retry_end_d_retry", bus.d_retry, 1'b0);
    cyc_start();
    set_d(1'b0, 1'b0, '0, '0); bus.mem_resp = 1'b0; bus.mem_retry = 1'b0;

    // dcache abandons its request after one granted cycle; icache arrives with the resp.
    cyc_start();
    set_d(1'b1, 1'b0, 32'h0000_5000, '0);
    cyc_start();
    settle();
    chk("drop_g1_mem_stb", bus.mem_stb, 1'b1);
    cyc_start();
    set_d(1'b0, 1'b0, 32'h0000_5000, '0);
    settle();
    chk("drop_g2_mem_stb", bus.mem_stb, 1'b1);
    chk("drop_g2_mem_addr", bus.mem_addr, 32'h0000_5000);
    chk("drop_g2_d_resp", bus.d_resp, 1'b0);
    cyc_start();
    bus.mem_resp = 1'b1;
    set_i(1'b1, 32'h0000_7000);
    settle();
    chk("drop_g3_d_resp", bus.d_resp, 1'b1);
    chk("drop_g3_i_retry", bus.i_retry, 1'b1);
    cyc_start();
    bus.mem_resp = 1'b0;
    settle();
    chk("drop_g4_mem_stb", bus.mem_stb, 1'b0);
    chk("drop_g4_d_resp", bus.d_resp, 1'b0);
    chk("drop_g4_i_retry", bus.i_retry, 1'b0);
    cyc_start();
    bus.mem_resp = 1'b1;
    settle();
    chk("drop_g5_mem_addr", bus.mem_addr, 32'h0000_7000);
    chk("drop_g5_i_resp", bus.i_resp, 1'b1);
    cyc_start();
    set_i(1'b0, '0); bus.mem_resp = 1'b0;

    // One-cycle reset during an icache grant.
    cyc_start();
    set_i(1'b1, 32'h0000_6000);
    cyc_start();
    settle();
    chk("rg_grant_mem_stb", bus.mem_stb, 1'b1);
    cyc_start();
    rst_n = 1'b0; bus.mem_resp = 1'b1; bus.mem_rdata = pat_a5;
    settle();
    chk("rg_rst_mem_stb", bus.mem_stb, 1'b0);
    chk("rg_rst_i_resp", bus.i_resp, 1'b0);
    chk("rg_rst_i_rdata", bus.i_rdata, '0);
    chk("rg_rst_mem_addr", bus.mem_addr, '0);
    cyc_start();
    rst_n = 1'b1; bus.mem_resp = 1'b0;
    settle();
    chk("rg_rel_mem_stb", bus.mem_stb, 1'b0);
    chk("rg_rel_i_retry", bus.i_retry, 1'b0);
    cyc_start();
    bus.mem_resp = 1'b1;
    settle();
    chk("rg_regrant_mem_stb", bus.mem_stb, 1'b1);
    chk("rg_regrant_mem_addr", bus.mem_addr, 32'h0000_6000);
    chk("rg_regrant_i_resp", bus.i_resp, 1'b1);
    cyc_start();
    set_i(1'b0, '0); bus.mem_resp = 1'b0;
    cyc_start();
    cyc_start();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port arbiter sharing the single physical-memory port between the instruction-cache controller and the data-cache eviction/write-back controller. Each cache controller issues stb/cyc/write line requests as if it owned memory. The arbiter grants one at a time and holds the grant until memory responds. It forwards resp/retry back to the granted side and issues retry to the losing side.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width of line requests
- LINE_WIDTH, 256, cache-line data width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_stb, i_cyc  in  1  icache request strobe/cycle (request = stb & cyc)
- i_write  in  1  icache write (normally 0)
- i_addr  in  ADDR_WIDTH  icache line address
- i_wdata  in  LINE_WIDTH  icache write line
- i_rdata  out  LINE_WIDTH  read line to icache
- i_resp, i_retry  out  1  icache completion / retry
- d_stb, d_cyc, d_write  in  1  dcache request and write flag
- d_addr  in  ADDR_WIDTH  dcache line address
- d_wdata  in  LINE_WIDTH  dcache write-back line
- d_rdata  out  LINE_WIDTH  read line to dcache
- d_resp, d_retry  out  1  dcache completion / retry
- mem_stb, mem_cyc, mem_write  out  1  physical memory request
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data
- mem_resp, mem_retry  in  1  memory completion / retry

## Operation
- States: IDLE, GRANT_I, GRANT_D. There is also a 1-bit last_grant register (0 = I, 1 = D).
- IDLE:
  - All mem_* outputs are 0.
  - Both requests pending: the winner is chosen per Configuration.
  - Single request pending: that side wins.
  - No request: stay in IDLE.
- GRANT_x:
  - mem_stb = mem_cyc = 1.
  - mem_write, mem_addr and mem_wdata are muxed combinationally from side x.
  - x_rdata = mem_rdata. The non-granted rdata is 0.
  - x_resp = mem_resp, combinationally.
  - x_retry = mem_retry & !mem_resp.
- Leaving GRANT_x: on mem_resp, go to IDLE and set last_grant = x.
- Grant holding:
  - The grant is held until mem_resp, even if x deasserts stb/cyc mid-transaction. The memory transaction must complete; the resp is still forwarded.
  - mem_retry does not release the grant. Memory lines stay driven.
- Losing side: retry = stb & cyc whenever that side is not granted, including the IDLE cycle in which the other side wins. Its resp is 0.
- The requester in IDLE that is being granted sees retry = 0.
- Simultaneous events: mem_resp in GRANT_x plus a new request from either side. The resp is forwarded, state goes to IDLE, and the new request is arbitrated in the following cycle.

## Timing
- Request first seen in IDLE at cycle N: grant registered at edge N+1, so mem_stb = 1 in cycle N+1.
- mem_resp in cycle M: x_resp = 1 in cycle M, with no added latency. State is IDLE in M+1; the next grant's mem_stb is earliest at M+2. There is one mandatory idle bubble between transactions.
- Reset, sampled at a rising edge with rst_n = 0:
  - State goes to IDLE and last_grant goes to 1 (so icache wins the first round-robin tie).
  - While rst_n = 0, all outputs are forced to 0, including retry and rdata.
- Reset mid-transaction: the grant is abandoned and mem_stb drops in the same cycle rst_n is low. No resp is forwarded for the aborted request.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, grant the side opposite last_grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, dcache always wins ties. last_grant is still maintained but unused.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then single icache read at address 0x0000_1000:
  - mem_stb = 1 and mem_addr = 0x1000 in cycle N+1.
  - mem_resp with mem_rdata = 0xA5..A5 gives i_resp = 1 and i_rdata = 0xA5..A5 in the same cycle.
  - IDLE on the following cycle.
- Simultaneous icache read and dcache write-back (d_addr = 0x2000) right after reset, round-robin build:
  - icache is granted first; d_retry = 1 throughout.
  - After i_resp, a bubble cycle follows, then mem_write = 1 with mem_addr = 0x2000.
- Same stimulus, fixed-priority build: dcache is granted first and i_retry = 1 until dcache completes.
- mem_retry asserted for 3 cycles during GRANT_D:
  - d_retry = 1 for those 3 cycles.
  - mem_addr and mem_wdata stay stable.
  - Grant is retained until mem_resp.
- dcache drops stb after 1 cycle of grant: mem_stb stays 1 until mem_resp, and d_resp pulses for 1 cycle.
- rst_n low for 1 cycle during GRANT_I:
  - All outputs are 0 that cycle; state is IDLE afterward.
  - The pending icache request is re-granted 1 cycle after reset releases.
